// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic multiplier and its result writer:
// side-length derivation, writer FSM states and the column-major element offset.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  function automatic int unsigned max_dim_of(input int unsigned bus_w, input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  // Result elements are stored column-major: e = col*dim + row.
  function automatic int unsigned idx(input logic [1:0] row, input logic [1:0] col,
                                      input int unsigned dim);
    return {30'b0, col} * dim + {30'b0, row};
  endfunction

endpackage

// File: rtl/matmul_result_writer.sv
// Snapshots the multiplier result on finish_mul rising edge and streams the
// valid N x M region row-major into the scratchpad, then pulses finish_write_o.
module matmul_result_writer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5,
  localparam int unsigned MAX_DIM = max_dim_of(BUS_WIDTH, DATA_WIDTH),
  localparam int unsigned NELEM   = MAX_DIM * MAX_DIM
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      finish_mul_i,
  input  logic [NELEM*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [NELEM-1:0]          flags_i,
  input  logic [1:0]                n_dim_i,
  input  logic [1:0]                m_dim_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  output logic                      wr_en_o,
  output logic [ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [BUS_WIDTH-1:0]      wr_data_o,
  input  logic                      wr_ready_i,
  output logic [NELEM-1:0]          flags_o,
  output logic                      busy_o,
  output logic                      finish_write_o
);

  localparam int EW = (NELEM > 1) ? $clog2(NELEM) : 1;

  state_e                  state_q, state_d;
  logic                    finish_mul_q, rise;
  logic                    capture, accept;
  logic [BUS_WIDTH-1:0]    snap_q [NELEM];
  logic [NELEM-1:0]        flags_q;
  logic [1:0]              n_q, m_q, row_q, col_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  int unsigned             elem;

  assign rise = finish_mul_i & ~finish_mul_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        capture = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (wr_ready_i) begin
        accept = 1'b1;
        if (row_q == n_q && col_q == m_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      finish_mul_q <= 1'b0;
      flags_q      <= '0;
      n_q          <= '0;
      m_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      base_q       <= '0;
      for (int e = 0; e < NELEM; e++) snap_q[e] <= '0;
    end else begin
      state_q      <= state_d;
      finish_mul_q <= finish_mul_i;
      if (capture) begin
        for (int e = 0; e < NELEM; e++) snap_q[e] <= c_matrix_i[(e+1)*BUS_WIDTH-1 -: BUS_WIDTH];
        flags_q <= flags_i;
        n_q     <= n_dim_i;
        m_q     <= m_dim_i;
        base_q  <= base_addr_i;
        row_q   <= '0;
        col_q   <= '0;
      end else if (accept) begin
        if (col_q < m_q) begin
          col_q <= col_q + 2'd1;
        end else begin
          col_q <= '0;
          row_q <= row_q + 2'd1;
        end
      end
    end
  end

  // Counters step past the region after the last accept; guard the lookup.
  always_comb begin
    elem      = idx(row_q, col_q, MAX_DIM);
    wr_data_o = (elem < NELEM) ? snap_q[elem[EW-1:0]] : '0;
  end

  assign wr_addr_o      = base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(col_q);
  assign wr_en_o        = (state_q == WRITE);
  assign finish_write_o = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign flags_o        = flags_q;

endmodule

// File: tb/tb_matmul_result_writer.sv
// Directed bench for matmul_result_writer: per-cycle vector table plus
// hand-written level/ignore and async-reset sequences.
module tb_matmul_result_writer;

  localparam int AW = 5;
  localparam int BW = 16;
  localparam int NE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fmul = 1'b0;
  logic [NE*BW-1:0] cmat = 64'h0004_0003_0002_0001;
  logic [NE-1:0]   flg = '0;
  logic [1:0]      n = '0, m = '0;
  logic [AW-1:0]   base = '0;
  logic            rdy = 1'b1;
  logic            en, fin, busy;
  logic [AW-1:0]   addr;
  logic [BW-1:0]   data;
  logic [NE-1:0]   flo;

  always #5 clk = ~clk;

  matmul_result_writer #(.DATA_WIDTH(8), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .finish_mul_i(fmul), .c_matrix_i(cmat), .flags_i(flg),
    .n_dim_i(n), .m_dim_i(m), .base_addr_i(base), .wr_en_o(en), .wr_addr_o(addr),
    .wr_data_o(data), .wr_ready_i(rdy), .flags_o(flo), .busy_o(busy), .finish_write_o(fin)
  );

  typedef struct {
    logic fmul; logic rdy; logic [1:0] n; logic [1:0] m; logic [AW-1:0] base; logic [NE-1:0] flg;
    logic en; logic [AW-1:0] addr; logic [BW-1:0] data; logic fin; logic busy; logic [NE-1:0] flo;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, k, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic f, input logic r, input logic [1:0] nn, input logic [1:0] mm,
                              input logic [AW-1:0] b, input logic [NE-1:0] fl, input logic e,
                              input logic [AW-1:0] a, input logic [BW-1:0] d, input logic fi,
                              input logic bz, input logic [NE-1:0] fo);
    vec_t v;
    v.fmul = f; v.rdy = r; v.n = nn; v.m = mm; v.base = b; v.flg = fl;
    v.en = e; v.addr = a; v.data = d; v.fin = fi; v.busy = bz; v.flo = fo;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_cnt, fin_cnt;

    // 2x2 basic, base 4
    vecs.push_back(mk(0,1,1,1,4,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,4,1,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,5,3,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,6,2,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,7,4,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 0,0,0,1,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 0,0,0,0,0,0));
    // backpressure: 3 stalled edges at the second write
    vecs.push_back(mk(0,1,1,1,4,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,4,1,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,5,3,0,1,0));
    vecs.push_back(mk(1,0,1,1,4,0, 1,5,3,0,1,0));
    vecs.push_back(mk(1,0,1,1,4,0, 1,5,3,0,1,0));
    vecs.push_back(mk(1,0,1,1,4,0, 1,5,3,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,6,2,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 1,7,4,0,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 0,0,0,1,1,0));
    vecs.push_back(mk(1,1,1,1,4,0, 0,0,0,0,0,0));
    // partial 1x2 with flags, base 10
    vecs.push_back(mk(0,1,0,1,10,4'b0100, 0,0,0,0,0,4'b0000));
    vecs.push_back(mk(1,1,0,1,10,4'b0100, 1,10,1,0,1,4'b0100));
    vecs.push_back(mk(1,1,0,1,10,4'b0100, 1,11,3,0,1,4'b0100));
    vecs.push_back(mk(1,1,0,1,10,4'b0100, 0,0,0,1,1,4'b0100));
    vecs.push_back(mk(1,1,0,1,10,4'b0100, 0,0,0,0,0,4'b0100));
    // address wrap from 31
    vecs.push_back(mk(0,1,1,1,31,0, 0,0,0,0,0,4'b0100));
    vecs.push_back(mk(1,1,1,1,31,0, 1,31,1,0,1,0));
    vecs.push_back(mk(1,1,1,1,31,0, 1,0,3,0,1,0));
    vecs.push_back(mk(1,1,1,1,31,0, 1,1,2,0,1,0));
    vecs.push_back(mk(1,1,1,1,31,0, 1,2,4,0,1,0));
    vecs.push_back(mk(1,1,1,1,31,0, 0,0,0,1,1,0));
    vecs.push_back(mk(1,1,1,1,31,0, 0,0,0,0,0,0));
    // 1x1, base 3
    vecs.push_back(mk(0,1,0,0,3,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,3,0, 1,3,1,0,1,0));
    vecs.push_back(mk(1,1,0,0,3,0, 0,0,0,1,1,0));
    vecs.push_back(mk(1,1,0,0,3,0, 0,0,0,0,0,0));

    #12;
    chk("rst_en", 0, 32'(en), 0);
    chk("rst_fin", 0, 32'(fin), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_flags", 0, 32'(flo), 0);
    chk("rst_addr", 0, 32'(addr), 0);
    chk("rst_data", 0, 32'(data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      fmul = vecs[k].fmul; rdy = vecs[k].rdy; n = vecs[k].n; m = vecs[k].m;
      base = vecs[k].base; flg = vecs[k].flg;
      step();
      chk("en", k, 32'(en), 32'(vecs[k].en));
      chk("fin", k, 32'(fin), 32'(vecs[k].fin));
      chk("busy", k, 32'(busy), 32'(vecs[k].busy));
      chk("flags", k, 32'(flo), 32'(vecs[k].flo));
      if (vecs[k].en) begin
        chk("addr", k, 32'(addr), 32'(vecs[k].addr));
        chk("data", k, 32'(data), 32'(vecs[k].data));
      end
    end

    // level held high with a second pulse while busy: one sequence only
    fmul = 1'b0; rdy = 1'b1; n = 2'd1; m = 2'd1; base = '0; flg = '0;
    step();
    fmul = 1'b1;
    wr_cnt = 0; fin_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) fmul = 1'b0;
      if (i == 3) fmul = 1'b1;
      step();
      if (en) wr_cnt++;
      if (fin) fin_cnt++;
    end
    chk("level_writes", 0, 32'(wr_cnt), 4);
    chk("level_fins", 0, 32'(fin_cnt), 1);

    // async reset after the first accept
    fmul = 1'b0;
    step();
    flg = 4'b1010; base = 5'd8;
    fmul = 1'b1;
    step();
    chk("rw_addr0", 0, 32'(addr), 8);
    step();
    chk("rw_addr1", 0, 32'(addr), 9);
    rst_n = 1'b0;
    #1;
    chk("rw_en", 0, 32'(en), 0);
    chk("rw_fin", 0, 32'(fin), 0);
    chk("rw_busy", 0, 32'(busy), 0);
    chk("rw_flags", 0, 32'(flo), 0);
    fmul = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rw_idle", 0, 32'(busy), 0);
    fmul = 1'b1;
    step();
    chk("rw_re_en", 0, 32'(en), 1);
    chk("rw_re_addr", 0, 32'(addr), 8);
    chk("rw_re_data", 0, 32'(data), 1);
    chk("rw_re_flags", 0, 32'(flo), 32'(4'b1010));
    fmul = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rw_end_busy", 0, 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
